// File: rtl/axil_stat_pkg.sv
// Shared definitions for the AXI4-Lite statistics register block.
//   - byte offsets of every mapped register
//   - AXI response codes
//   - CTRL register layout and the register-select enum used by the decoder
//   - a byte-lane merge helper for WSTRB handling
package axil_stat_pkg;

  localparam logic [7:0] CTRL_OFF    = 8'h00;
  localparam logic [7:0] STATUS_OFF  = 8'h04;
  localparam logic [7:0] RX_PKT_OFF  = 8'h10;
  localparam logic [7:0] TX_PKT_OFF  = 8'h14;
  localparam logic [7:0] RX_BEAT_OFF = 8'h18;
  localparam logic [7:0] SCRATCH_OFF = 8'h20;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // clear is a write-1 pulse and is never stored, so it always reads 0
  typedef struct packed {
    logic [29:0] rsvd;
    logic        clear;
    logic        enable;
  } ctrl_t;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_RX_PKT,
    REG_TX_PKT,
    REG_RX_BEAT,
    REG_SCRATCH,
    REG_NONE
  } reg_sel_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Snoops one AXI-Stream handshake and keeps packet/beat statistics.
// Ports:
//   clk_sys, rst_b        clock, async active-low reset
//   valid, ready, last    snooped AXIS handshake
//   enable                counters advance only while set
//   clear                 synchronous zero of both counters; wins over increment
//   pkt_cnt, beat_cnt     wrapping counters (tlast beats, all beats)
//   busy                  packet in flight: set on a non-last beat, cleared on tlast
module axis_beat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             valid,
  input  logic             ready,
  input  logic             last,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  logic [CNT_W-1:0] pkt_cnt_d,  pkt_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d, beat_cnt_q;
  logic             busy_d,     busy_q;
  logic             beat;

  assign beat = valid & ready;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;

    // busy tracks framing only; it ignores enable and clear
    if (beat) begin
      busy_d = ~last;
    end

    if (clear) begin
      pkt_cnt_d  = '0;
      beat_cnt_d = '0;
    end else if (enable && beat) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (last) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign busy     = busy_q;

endmodule

// File: rtl/axil_stat_regs.sv
// AXI4-Lite responder holding control, scratch and stream statistics.
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   s_axi_control_*             AXI4-Lite slave (AW/W/B, AR/R)
//   in_tvalid/tready/tlast      input stream handshake, snooped
//   out_tvalid/tready/tlast     output stream handshake, snooped
//   ctrl_enable                 CTRL[0], kernel enable
// Only byte address bits [ADDR_W-1:2] take part in decode.
module axil_stat_regs
  import axil_stat_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] s_axi_control_AWADDR,
  input  logic              s_axi_control_AWVALID,
  output logic              s_axi_control_AWREADY,
  input  logic [31:0]       s_axi_control_WDATA,
  input  logic [3:0]        s_axi_control_WSTRB,
  input  logic              s_axi_control_WVALID,
  output logic              s_axi_control_WREADY,
  output logic [1:0]        s_axi_control_BRESP,
  output logic              s_axi_control_BVALID,
  input  logic              s_axi_control_BREADY,
  input  logic [ADDR_W-1:0] s_axi_control_ARADDR,
  input  logic              s_axi_control_ARVALID,
  output logic              s_axi_control_ARREADY,
  output logic [31:0]       s_axi_control_RDATA,
  output logic [1:0]        s_axi_control_RRESP,
  output logic              s_axi_control_RVALID,
  input  logic              s_axi_control_RREADY,
  input  logic              in_tvalid,
  input  logic              in_tready,
  input  logic              in_tlast,
  input  logic              out_tvalid,
  input  logic              out_tready,
  input  logic              out_tlast,
  output logic              ctrl_enable
);

  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    a = addr & ~ADDR_W'(3);
    if      (a == ADDR_W'(CTRL_OFF))    return REG_CTRL;
    else if (a == ADDR_W'(STATUS_OFF))  return REG_STATUS;
    else if (a == ADDR_W'(RX_PKT_OFF))  return REG_RX_PKT;
    else if (a == ADDR_W'(TX_PKT_OFF))  return REG_TX_PKT;
    else if (a == ADDR_W'(RX_BEAT_OFF)) return REG_RX_BEAT;
    else if (a == ADDR_W'(SCRATCH_OFF)) return REG_SCRATCH;
    else                                return REG_NONE;
  endfunction

  logic        awready_d, awready_q;
  logic        bvalid_d,  bvalid_q;
  logic [1:0]  bresp_d,   bresp_q;
  logic        arready_d, arready_q;
  logic        rvalid_d,  rvalid_q;
  logic [1:0]  rresp_d,   rresp_q;
  logic [31:0] rdata_d,   rdata_q;
  ctrl_t       ctrl_d,    ctrl_q;
  logic [31:0] scratch_d, scratch_q;

  logic        wr_hs, rd_hs;
  logic        clear_pulse;
  reg_sel_e    wr_sel, rd_sel;

  logic [CNT_W-1:0] rx_pkt, rx_beat, tx_pkt, tx_beat_unused;
  logic             in_busy, out_busy;

  // A write is taken in the cycle AWREADY/WREADY are high; both channels
  // are accepted together, so one ready flop serves both.
  assign wr_hs  = awready_q & s_axi_control_AWVALID & s_axi_control_WVALID;
  assign rd_hs  = arready_q & s_axi_control_ARVALID;
  assign wr_sel = decode_addr(s_axi_control_AWADDR);
  assign rd_sel = decode_addr(s_axi_control_ARADDR);

  always_comb begin
    awready_d   = s_axi_control_AWVALID & s_axi_control_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d    = bvalid_q & ~s_axi_control_BREADY;
    bresp_d     = bresp_q;
    ctrl_d      = ctrl_q;
    ctrl_d.clear = 1'b0;
    ctrl_d.rsvd  = '0;
    scratch_d   = scratch_q;
    clear_pulse = 1'b0;

    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      case (wr_sel)
        REG_CTRL: begin
          if (s_axi_control_WSTRB[0]) begin
            ctrl_d.enable = s_axi_control_WDATA[0];
            // applied to the counters this same cycle so it beats any increment
            clear_pulse   = s_axi_control_WDATA[1];
          end
        end
        REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, s_axi_control_WDATA,
                                             s_axi_control_WSTRB);
        default: ;
      endcase
    end
  end

  always_comb begin
    arready_d = s_axi_control_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q & ~s_axi_control_RREADY;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    // snapshot uses the registered counters, i.e. the pre-increment value
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (rd_sel)
        REG_CTRL:    rdata_d = ctrl_q;
        REG_STATUS:  rdata_d = {30'b0, out_busy, in_busy};
        REG_RX_PKT:  rdata_d = 32'(rx_pkt);
        REG_TX_PKT:  rdata_d = 32'(tx_pkt);
        REG_RX_BEAT: rdata_d = 32'(rx_beat);
        REG_SCRATCH: rdata_d = scratch_q;
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
    end
  end

  axis_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk_sys  (ap_clk),
    .rst_b    (ap_rst_n),
    .valid    (in_tvalid),
    .ready    (in_tready),
    .last     (in_tlast),
    .enable   (ctrl_q.enable),
    .clear    (clear_pulse),
    .pkt_cnt  (rx_pkt),
    .beat_cnt (rx_beat),
    .busy     (in_busy)
  );

  // output-side beat count has no register slot
  axis_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk_sys  (ap_clk),
    .rst_b    (ap_rst_n),
    .valid    (out_tvalid),
    .ready    (out_tready),
    .last     (out_tlast),
    .enable   (ctrl_q.enable),
    .clear    (clear_pulse),
    .pkt_cnt  (tx_pkt),
    .beat_cnt (tx_beat_unused),
    .busy     (out_busy)
  );

  assign s_axi_control_AWREADY = awready_q;
  assign s_axi_control_WREADY  = awready_q;
  assign s_axi_control_BVALID  = bvalid_q;
  assign s_axi_control_BRESP   = bresp_q;
  assign s_axi_control_ARREADY = arready_q;
  assign s_axi_control_RVALID  = rvalid_q;
  assign s_axi_control_RRESP   = rresp_q;
  assign s_axi_control_RDATA   = rdata_q;
  assign ctrl_enable           = ctrl_q.enable;

endmodule

// File: tb/tb_axil_stat_regs.sv
module tb_axil_stat_regs;
  import axil_stat_pkg::*;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ADDR_W-1:0] araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic              in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
  logic              out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic              ctrl_enable;

  int n_pass  = 0;
  int n_total = 0;

  always #5 ap_clk = ~ap_clk;

  axil_stat_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .s_axi_control_AWADDR  (awaddr),
    .s_axi_control_AWVALID (awvalid),
    .s_axi_control_AWREADY (awready),
    .s_axi_control_WDATA   (wdata),
    .s_axi_control_WSTRB   (wstrb),
    .s_axi_control_WVALID  (wvalid),
    .s_axi_control_WREADY  (wready),
    .s_axi_control_BRESP   (bresp),
    .s_axi_control_BVALID  (bvalid),
    .s_axi_control_BREADY  (bready),
    .s_axi_control_ARADDR  (araddr),
    .s_axi_control_ARVALID (arvalid),
    .s_axi_control_ARREADY (arready),
    .s_axi_control_RDATA   (rdata),
    .s_axi_control_RRESP   (rresp),
    .s_axi_control_RVALID  (rvalid),
    .s_axi_control_RREADY  (rready),
    .in_tvalid             (in_tvalid),
    .in_tready             (in_tready),
    .in_tlast              (in_tlast),
    .out_tvalid            (out_tvalid),
    .out_tready            (out_tready),
    .out_tlast             (out_tlast),
    .ctrl_enable           (ctrl_enable)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic wait_awready();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) check("aw_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bvalid();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1; break; end
      @(negedge ap_clk);
    end
    if (!ok) check("b_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    @(negedge ap_clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    check("wready_with_awready", {31'b0, wready}, 32'd1);
    @(negedge ap_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid();
    resp = bresp;
    @(negedge ap_clk);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit lat_ok);
    bit ok = 0;
    @(negedge ap_clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) check("ar_accept_timeout", 32'd0, 32'd1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    lat_ok = rvalid;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin ok = 1; break; end
      @(negedge ap_clk);
    end
    if (!ok) check("r_valid_timeout", 32'd0, 32'd1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge ap_clk);
    rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d; logic [1:0] r; bit lat;
    axi_read(addr, d, r, lat);
    check({name, "_data"}, d, exp_data);
    check({name, "_resp"}, {30'b0, r}, {30'b0, exp_resp});
  endtask

  task automatic write_check(input string name, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    check({name, "_bresp"}, {30'b0, r}, {30'b0, exp_resp});
  endtask

  // Starts and ends on a negedge. Beat 1 is preceded by a stall (valid without ready).
  task automatic send_in(input int beats);
    for (int b = 0; b < beats; b++) begin
      if (b == 1) begin
        in_tvalid = 1'b1; in_tready = 1'b0; in_tlast = 1'b0;
        @(negedge ap_clk);
      end
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = (b == beats - 1);
      @(negedge ap_clk);
    end
    in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic send_out(input int beats);
    for (int b = 0; b < beats; b++) begin
      out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = (b == beats - 1);
      @(negedge ap_clk);
      if (b == 0) begin
        out_tvalid = 1'b0; out_tready = 1'b1; out_tlast = 1'b1;
        @(negedge ap_clk);
      end
    end
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
  endtask

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        strb;
    logic [31:0]       exp_data;
    logic [1:0]        exp_resp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          lat;
    bit          ok;

    vecs[0]  = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
    vecs[1]  = '{1'b1, 6'h20, 32'd100,      4'hF, 32'h0,        RESP_OKAY};
    vecs[2]  = '{1'b0, 6'h20, 32'h0,        4'h0, 32'd100,      RESP_OKAY};
    vecs[3]  = '{1'b1, 6'h20, 32'hFFFFFFFF, 4'h1, 32'h0,        RESP_OKAY};
    vecs[4]  = '{1'b0, 6'h20, 32'h0,        4'h0, 32'h000000FF, RESP_OKAY};
    vecs[5]  = '{1'b1, 6'h23, 32'hAB000000, 4'h8, 32'h0,        RESP_OKAY};
    vecs[6]  = '{1'b0, 6'h21, 32'h0,        4'h0, 32'hAB0000FF, RESP_OKAY};
    vecs[7]  = '{1'b1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_OKAY};
    vecs[8]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
    vecs[9]  = '{1'b1, 6'h3C, 32'h12345678, 4'hF, 32'h0,        RESP_SLVERR};
    vecs[10] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
    vecs[11] = '{1'b1, 6'h00, 32'h3,        4'hF, 32'h0,        RESP_OKAY};
    vecs[12] = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h1,        RESP_OKAY};
    vecs[13] = '{1'b1, 6'h00, 32'h0,        4'hF, 32'h0,        RESP_OKAY};
    vecs[14] = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
    vecs[15] = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
    vecs[16] = '{1'b1, 6'h10, 32'h5,        4'hF, 32'h0,        RESP_OKAY};
    vecs[17] = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h0,        RESP_OKAY};

    // reset state
    #12;
    check("reset_handshakes", {26'b0, awready, wready, bvalid, arready, rvalid, ctrl_enable}, 32'd0);
    check("reset_resp", {28'b0, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // first read after reset, with read latency check
    axi_read(6'h10, d, r, lat);
    check("first_read_latency", {31'b0, lat}, 32'd1);

    // register map vectors
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, d, r, lat);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
        check($sformatf("vec%0d_latency", i), {31'b0, lat}, 32'd1);
      end
    end

    // counting enabled
    write_check("ctrl_en", 6'h00, 32'h1, 4'hF, RESP_OKAY);
    check("ctrl_enable_pin", {31'b0, ctrl_enable}, 32'd1);
    for (int p = 0; p < 3; p++) send_in(4);
    out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b0;
    @(negedge ap_clk);
    out_tvalid = 1'b0; out_tready = 1'b0;
    read_check("status_out_busy", 6'h04, 32'h2, RESP_OKAY);
    out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b1;
    @(negedge ap_clk);
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    send_out(3);
    read_check("rx_pkt_3", 6'h10, 32'd3, RESP_OKAY);
    read_check("rx_beat_12", 6'h18, 32'd12, RESP_OKAY);
    read_check("tx_pkt_2", 6'h14, 32'd2, RESP_OKAY);
    read_check("status_idle", 6'h04, 32'h0, RESP_OKAY);

    // counting disabled
    write_check("ctrl_dis", 6'h00, 32'h0, 4'hF, RESP_OKAY);
    send_in(4); send_in(4); send_out(2);
    read_check("rx_pkt_hold", 6'h10, 32'd3, RESP_OKAY);
    read_check("rx_beat_hold", 6'h18, 32'd12, RESP_OKAY);
    read_check("tx_pkt_hold", 6'h14, 32'd2, RESP_OKAY);

    // wrap from all-ones
    write_check("ctrl_en2", 6'h00, 32'h1, 4'hF, RESP_OKAY);
    @(negedge ap_clk);
    force dut.u_in_cnt.pkt_cnt_q = 32'hFFFFFFFF;
    @(negedge ap_clk);
    release dut.u_in_cnt.pkt_cnt_q;
    in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
    @(negedge ap_clk);
    in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
    read_check("rx_pkt_wrap", 6'h10, 32'd0, RESP_OKAY);
    read_check("rx_beat_13", 6'h18, 32'd13, RESP_OKAY);

    // clear leaves busy alone
    in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b0;
    @(negedge ap_clk);
    in_tvalid = 1'b0; in_tready = 1'b0;
    write_check("ctrl_clear_busy", 6'h00, 32'h3, 4'hF, RESP_OKAY);
    read_check("busy_after_clear", 6'h04, 32'h1, RESP_OKAY);
    read_check("rx_beat_cleared", 6'h18, 32'd0, RESP_OKAY);
    send_in(2);   // 2 beats, 1 packet

    // clear in the same cycle as a tlast beat
    @(negedge ap_clk);
    awaddr = 6'h00; wdata = 32'h3; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_awready();
    in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
    @(negedge ap_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
    check("clear_tlast_bvalid", {31'b0, bvalid}, 32'd1);
    @(negedge ap_clk);
    read_check("clear_wins_pkt", 6'h10, 32'd0, RESP_OKAY);
    read_check("clear_wins_beat", 6'h18, 32'd0, RESP_OKAY);
    read_check("ctrl_reads_1", 6'h00, 32'h1, RESP_OKAY);

    // B held off: no new write accepted
    @(negedge ap_clk);
    awaddr = 6'h3C; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    wait_awready();
    @(negedge ap_clk);
    awaddr = 6'h20; wdata = 32'h55;
    check("hold_bresp_slverr", {30'b0, bresp}, {30'b0, RESP_SLVERR});
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_bvalid_c%0d", i), {31'b0, bvalid}, 32'd1);
      check($sformatf("hold_awready_c%0d", i), {31'b0, awready}, 32'd0);
      @(negedge ap_clk);
    end
    bready = 1'b1;
    @(negedge ap_clk);
    check("bvalid_dropped", {31'b0, bvalid}, 32'd0);
    wait_awready();
    @(negedge ap_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid();
    check("pending_write_bresp", {30'b0, bresp}, {30'b0, RESP_OKAY});
    @(negedge ap_clk);
    read_check("pending_write_data", 6'h20, 32'h55, RESP_OKAY);

    // reset while RVALID is high
    @(negedge ap_clk);
    araddr = 6'h20; arvalid = 1'b1; rready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) check("rst_ar_timeout", 32'd0, 32'd1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    check("rvalid_before_reset", {31'b0, rvalid}, 32'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("rvalid_async_reset", {31'b0, rvalid}, 32'd0);
    check("rdata_async_reset", rdata, 32'd0);
    check("enable_async_reset", {31'b0, ctrl_enable}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    axi_read(6'h20, d, r, lat);
    check("post_reset_scratch", d, 32'd0);
    check("post_reset_resp", {30'b0, r}, 32'd0);
    check("post_reset_latency", {31'b0, lat}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
